reg_writeback_arbiter: RTL
==========================

Name: reg_writeback_arbiter

Overview:
- Write-side partner of the register file. Merges fixed-latency ALU results and handshaked long-latency results (load/multiply unit) onto the single register-file write port (RegWrite/RDaddr/RDdata).
- Buffers long-latency results that lose arbitration.
- Keeps a per-register pending scoreboard that the hazard unit queries.
- Sits between EX/MEM result sources and the register file in the pipeline.

Parameters:
DATA_W, 32, data width of a result
ADDR_W, 5, register address width (32 registers)
FIFO_DEPTH, 4, long-result buffer entries; power of 2, minimum 2

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
alu_valid_i  in  1  ALU result valid this cycle; has no backpressure
alu_rd_i  in  ADDR_W  ALU destination register
alu_data_i  in  DATA_W  ALU result
long_issue_i  in  1  long op issued this cycle; marks long_issue_rd_i pending
long_issue_rd_i  in  ADDR_W  destination register of the issued long op
long_valid_i  in  1  long result offered
long_ready_o  out  1  long result accepted when valid and ready are both high
long_rd_i  in  ADDR_W  long result destination register
long_data_i  in  DATA_W  long result data
wb_we_o  out  1  register-file write enable
wb_addr_o  out  ADDR_W  register-file write address
wb_data_o  out  DATA_W  register-file write data
rs_addr_i, rt_addr_i, rd_addr_i  in  ADDR_W each  scoreboard query addresses
rs_busy_o, rt_busy_o, rd_busy_o  out  1 each  queried register has a long write outstanding (combinational)
fifo_count_o  out  $clog2(FIFO_DEPTH)+1  buffered entries
err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst_i high at edge):
  - wb_we_o=0, wb_addr_o=0, wb_data_o=0.
  - FIFO emptied, scoreboard all 0, err_o=0.
  - long_ready_o=0 while rst_i is high.
  - Reset mid-operation discards buffered results and pending bits; upstream flushes in-flight long ops.
- The write port is registered. A source selected in cycle t appears on wb_* in cycle t+1. wb_we_o stays high for exactly one cycle per write.
- Priority each cycle:
  - alu_valid_i with alu_rd_i!=0: ALU result goes to the write port.
  - Otherwise, FIFO non-empty: pop the head to the write port.
  - Otherwise: wb_we_o=0 next cycle; wb_addr_o and wb_data_o hold their values.
- long_ready_o = (fifo_count_o < FIFO_DEPTH). An accepted long result is pushed at the edge.
  - Push and pop in the same cycle are legal when full: ready is evaluated before the pop, so the full case still stalls the producer for that cycle.
- Latency, no feature, idle port: long handshake at t, FIFO at t+1, pop at t+1, wb_we_o at t+2.
- Register 0:
  - ALU writes to 0 are dropped, and the port is then free for a FIFO drain.
  - Long results to 0 are accepted but not buffered.
  - Issue to 0 never sets pending.
  - busy for address 0 is always 0.
- Scoreboard:
  - Pending[r] is set at the edge where long_issue_i is high.
  - Pending[r] is cleared at the edge where an entry for r loads the write-port register.
  - When a set and a clear hit the same r in one cycle, the set wins.
  - busy_o reads pending combinationally. A register clears in the same cycle its write is on wb_*, and the register file's same-cycle write-through supplies the value.
- err_o sets, and holds until reset, on any of:
  - long issue to an already-pending register that is not clearing this cycle
  - ALU write to a pending register (WAW; the hazard unit must stall on rd_busy_o)
  - accepted long result whose register is not pending

Optional Feature:
- Macro WB_LONG_BYPASS_EN.
- Defined: when the FIFO is empty and no ALU write is selected, an accepted long result loads the write-port register directly. Latency is 1 cycle (wb_we_o at t+1). Results still go to the FIFO when the port is taken.
- Undefined: all long results pass through the FIFO, with minimum latency 2.

Decomposition:
- Package wb_pkg:
  - DATA_W and ADDR_W defaults
  - ZERO_REG constant
  - wb_entry_t struct {rd, data}
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t with push/pop/full/empty/count; same-cycle push and pop are legal.
- Scoreboard and arbitration stay in the top module.

Test Plan:
- ALU only: alu_valid_i=1, rd=3, data=0x11 at cycle 5 -> wb_we_o=1, addr=3, data=0x11 at cycle 6 only.
- Conflict: issue rd=7; long result rd=7, data=0xAA accepted at cycle 10 while ALU writes rd=2 at cycles 10-11 -> rd=2 writes at cycles 11-12; rd=7 write at cycle 13; rd_busy_o for 7 falls at cycle 13.
- Full buffer: ALU valid every cycle, 5 long results offered -> 4 accepted, long_ready_o=0, fifo_count_o=4; ALU idle -> 4 drains in FIFO order on consecutive cycles.
- Register 0: ALU rd=0 plus one buffered entry in the same cycle -> the FIFO entry is written next cycle and no write to 0 ever appears.
- Errors: ALU write to pending rd=9 -> err_o=1 and held; rst_i for 1 cycle -> err_o=0, count=0, all busy 0.
- With WB_LONG_BYPASS_EN: FIFO empty, ALU idle, long rd=4 accepted at t -> wb_we_o at t+1; without the macro -> t+2.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, register-zero constant and writeback entry type
package wb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries; ports clk/rst, push/din, pop/dout, full/empty/count; same-cycle push and pop allowed
module wb_fifo import wb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter type T = wb_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter: merges ALU and long-latency results onto one register-file write port, with long-result buffer and pending scoreboard
// Ports: clk_i/rst_i; alu_* fixed-latency source; long_issue_* marks pending; long_* handshaked source;
// wb_* registered write port; rs/rt/rd_addr_i -> *_busy_o scoreboard queries; fifo_count_o; sticky err_o.
// Optional macro WB_LONG_BYPASS_EN: long result goes straight to the write port when FIFO empty and ALU idle.
module reg_writeback_arbiter import wb_pkg::*; #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alu_valid_i,
  input  logic [ADDR_W-1:0]             alu_rd_i,
  input  logic [DATA_W-1:0]             alu_data_i,
  input  logic                          long_issue_i,
  input  logic [ADDR_W-1:0]             long_issue_rd_i,
  input  logic                          long_valid_i,
  output logic                          long_ready_o,
  input  logic [ADDR_W-1:0]             long_rd_i,
  input  logic [DATA_W-1:0]             long_data_i,
  output logic                          wb_we_o,
  output logic [ADDR_W-1:0]             wb_addr_o,
  output logic [DATA_W-1:0]             wb_data_o,
  input  logic [ADDR_W-1:0]             rs_addr_i,
  input  logic [ADDR_W-1:0]             rt_addr_i,
  input  logic [ADDR_W-1:0]             rd_addr_i,
  output logic                          rs_busy_o,
  output logic                          rt_busy_o,
  output logic                          rd_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          err_o
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;
  entry_t head;
  logic full, empty, alu_sel, acc_nz, pop, byp, push, clr_en, iss_nz, wr_en, err_n;
  logic [ADDR_W-1:0] clr_rd;
  logic [NREG-1:0] pending, set_mask, clr_mask;
  // ready looks at occupancy before this cycle's pop, so a full buffer stalls the producer
  assign long_ready_o = !rst_i && !full;
  assign alu_sel = alu_valid_i && alu_rd_i != ZR;
  assign acc_nz = long_valid_i && long_ready_o && long_rd_i != ZR;
  assign pop = !alu_sel && !empty;
`ifdef WB_LONG_BYPASS_EN
  assign byp = !alu_sel && empty && acc_nz;
`else
  assign byp = 1'b0;
`endif
  assign push = acc_nz && !byp;
  assign wr_en = alu_sel || pop || byp;
  assign clr_en = pop || byp;
  assign clr_rd = pop ? head.rd : long_rd_i;
  assign iss_nz = long_issue_i && long_issue_rd_i != ZR;
  assign set_mask = NREG'(iss_nz) << long_issue_rd_i;
  assign clr_mask = NREG'(clr_en) << clr_rd;
  assign err_n = (iss_nz && pending[long_issue_rd_i] && !(clr_en && clr_rd == long_issue_rd_i))
              || (alu_sel && pending[alu_rd_i])
              || (acc_nz && !pending[long_rd_i]);
  assign rs_busy_o = pending[rs_addr_i];
  assign rt_busy_o = pending[rt_addr_i];
  assign rd_busy_o = pending[rd_addr_i];
  wb_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(push),
    .din(entry_t'{rd: long_rd_i, data: long_data_i}),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count_o)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_we_o <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      pending <= '0;
      err_o <= 1'b0;
    end else begin
      wb_we_o <= wr_en;
      if (wr_en) begin
        wb_addr_o <= alu_sel ? alu_rd_i : pop ? head.rd : long_rd_i;
        wb_data_o <= alu_sel ? alu_data_i : pop ? head.data : long_data_i;
      end
      // set is applied after clear so a same-cycle reissue keeps the register pending
      pending <= (pending & ~clr_mask) | set_mask;
      err_o <= err_o | err_n;
    end
  end
endmodule
